// File: rtl/keccak_pkg.sv
// Shared Keccak constants, theta_apply FSM states and the lane-index helper.
package keccak_pkg;

    localparam int SLICES = 64;
    localparam int LANE_W = 25;
    localparam int PAR_W  = 320;
    localparam int ADR_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_HOLD
    } state_t;

    // Bit position of lane (x,y) inside a slice.
    function automatic int idx(input int x, input int y);
        return x + 5 * y;
    endfunction

endpackage

// File: rtl/theta_apply_if.sv
// 25-bit slice port of Memory, as driven by theta_apply (master) and served by Memory (slave).
interface theta_apply_if;

    logic [keccak_pkg::ADR_W-1:0]  mem_adr;
    logic [0:keccak_pkg::LANE_W-1] mem_in;
    logic [0:keccak_pkg::LANE_W-1] mem_out;
    logic                          mem_r;
    logic                          mem_w;

    modport master (
        output mem_adr,
        output mem_in,
        output mem_r,
        output mem_w,
        input  mem_out
    );

    modport slave (
        input  mem_adr,
        input  mem_in,
        input  mem_r,
        input  mem_w,
        output mem_out
    );

endinterface

// File: rtl/theta_d.sv
// Theta correction for one slice: D[x] = C[x-1][z] ^ C[x+1][z-1], replicated over all five rows.
module theta_d
    import keccak_pkg::*;
(
    input  logic [0:4]        c_cur,
    input  logic [0:4]        c_prev,
    output logic [0:LANE_W-1] mask
);

    logic [0:4] d;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_col
            assign d[gi] = c_cur[(gi + 4) % 5] ^ c_prev[(gi + 1) % 5];
            for (genvar gj = 0; gj < 5; gj++) begin : g_row
                assign mask[idx(gi, gj)] = d[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/theta_apply.sv
// Theta read-modify-write over all 64 slices of Memory using latched column parities.
// Optional THETA_APPLY_ERR_EN adds a sticky err flag for start re-assertion while busy.
module theta_apply
    import keccak_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [0:PAR_W-1]   parity,
    theta_apply_if.master      mem,
    output logic               done,
`ifdef THETA_APPLY_ERR_EN
    output logic               err,
`endif
    output logic               busy
);

    state_t             state_reg, state_next;
    logic [ADR_W-1:0]   z_reg;
    logic [0:PAR_W-1]   par_reg;
    logic [0:LANE_W-1]  slice_reg;
    logic [0:LANE_W-1]  mask;
    logic [ADR_W-1:0]   z_prev;
    logic [8:0]         base_cur;
    logic [8:0]         base_prev;
    logic               last_slice;

    // z-1 wraps naturally in six bits, so slice 0 picks up the parity of slice 63.
    assign z_prev     = z_reg - 1'b1;
    assign base_cur   = 9'(z_reg) * 9'd5;
    assign base_prev  = 9'(z_prev) * 9'd5;
    assign last_slice = (z_reg == ADR_W'(SLICES - 1));

    theta_d u_theta_d (
        .c_cur  (par_reg[base_cur  +: 5]),
        .c_prev (par_reg[base_prev +: 5]),
        .mask   (mask)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_READ;
            ST_READ:  state_next = ST_WRITE;
            ST_WRITE: state_next = last_slice ? ST_DONE : ST_READ;
            ST_DONE:  state_next = ST_HOLD;
            ST_HOLD:  if (!start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_adr = '0;
        mem.mem_in  = '0;
        mem.mem_r   = 1'b0;
        mem.mem_w   = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        case (state_reg)
            ST_READ: begin
                mem.mem_adr = z_reg;
                mem.mem_r   = 1'b1;
                busy        = 1'b1;
            end
            ST_WRITE: begin
                mem.mem_adr = z_reg;
                mem.mem_w   = 1'b1;
                mem.mem_in  = slice_reg ^ mask;
                busy        = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Parity is captured once per run so Colparity may move on immediately.
    always_ff @(posedge clock) begin
        if (!reset) begin
            z_reg     <= '0;
            par_reg   <= '0;
            slice_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        par_reg <= parity;
                        z_reg   <= '0;
                    end
                end
                ST_READ:  slice_reg <= mem.mem_out;
                ST_WRITE: if (!last_slice) z_reg <= z_reg + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef THETA_APPLY_ERR_EN
    logic start_d_reg;
    logic err_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            start_d_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            start_d_reg <= start;
            if (start && !start_d_reg && busy) err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_theta_apply.sv
// Self-checking bench for theta_apply: vector table of runs plus reset, held-start and err sequences.
module tb_theta_apply;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [0:319] par;
    logic         done;
    logic         busy;
`ifdef THETA_APPLY_ERR_EN
    logic         err;
`endif

    theta_apply_if mif ();

    theta_apply dut (
        .clock  (clk),
        .reset  (rst_n),
        .start  (start),
        .parity (par),
        .mem    (mif),
        .done   (done),
`ifdef THETA_APPLY_ERR_EN
        .err    (err),
`endif
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:24] mem     [64];
    logic [0:24] ref_mem [64];
    logic [0:24] orig    [64];
    assign mif.mem_out = mem[mif.mem_adr];

    typedef struct {
        int          adr;
        logic [0:24] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [0:319] par;
        int           init;
        bit           hand;
        int           za;
        logic [0:24]  ea;
        int           zb;
        logic [0:24]  eb;
    } vec_t;
    vec_t tv[5];

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int e0       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [0:24] dmask(input logic [0:319] p, input int z);
        logic [0:24] m;
        logic        d;
        int          zp;
        m  = '0;
        zp = (z + 63) % 64;
        for (int x = 0; x < 5; x++) begin
            d = p[5 * z + (x + 4) % 5] ^ p[5 * zp + (x + 1) % 5];
            for (int y = 0; y < 5; y++) m[x + 5 * y] = d;
        end
        return m;
    endfunction

    // One cycle: sample at the falling edge, check writes against the scoreboard, model the memory.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc_n++;
        if (mif.mem_w) begin
            chk("rw_excl", 64'(mif.mem_r), 64'd0);
            chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("wr_adr z=%0d", e.adr), 64'(mif.mem_adr), 64'(e.adr));
                chk($sformatf("wr_data z=%0d", e.adr), 64'(mif.mem_in), 64'(e.data));
            end
            mem[mif.mem_adr] = mif.mem_in;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
    endtask

    task automatic rand_par(output logic [0:319] p);
        logic [31:0] r;
        p = '0;
        for (int i = 0; i < 10; i++) begin
            r = $urandom();
            p[32 * i +: 32] = r;
        end
    endtask

    task automatic init_mem(input int kind);
        logic [31:0] r;
        for (int z = 0; z < 64; z++) begin
            r = $urandom();
            case (kind)
                0:       mem[z] = 25'(z);
                1:       mem[z] = '0;
                default: mem[z] = r[24:0];
            endcase
            ref_mem[z] = mem[z];
            orig[z]    = mem[z];
        end
    endtask

    // Queue the expected writes, raise start, and step into cycle 1; parity is then scrambled.
    task automatic drive_start(input logic [0:319] p);
        wr_t         e;
        logic [0:319] junk;
        for (int z = 0; z < 64; z++) begin
            e.adr  = z;
            e.data = ref_mem[z] ^ dmask(p, z);
            exp_q.push_back(e);
            ref_mem[z] = e.data;
        end
        par   = p;
        start = 1'b1;
        tick();
        e0 = cyc_n;
        rand_par(junk);
        par = junk;
    endtask

    task automatic wait_done(input int bound);
        int base;
        int n;
        base = done_cnt;
        n    = 0;
        while (done_cnt == base && n < bound) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done_cnt > base), 64'd1);
    endtask

    task automatic mem_cmp(input string name, input logic [0:24] want [64]);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int z = 0; z < 64; z++) begin
            if (mem[z] !== want[z]) begin
                bad++;
                if (first < 0) first = z;
            end
        end
        chk($sformatf("%s mismatched_slices(first=%0d)", name, first), 64'(bad), 64'd0);
    endtask

    initial begin
        logic [0:319] p;
        int           base;
        logic [0:24]  snap [64];

        rst_n = 1'b0;
        start = 1'b0;
        par   = '0;
        init_mem(1);
        repeat (3) tick();
        chk("rst_mem_adr", 64'(mif.mem_adr), 64'd0);
        chk("rst_mem_in",  64'(mif.mem_in),  64'd0);
        chk("rst_mem_r",   64'(mif.mem_r),   64'd0);
        chk("rst_mem_w",   64'(mif.mem_w),   64'd0);
        chk("rst_done",    64'(done),        64'd0);
        chk("rst_busy",    64'(busy),        64'd0);
`ifdef THETA_APPLY_ERR_EN
        chk("rst_err",     64'(err),         64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Vector table: parity, memory preload kind, and optional hand-derived slice values.
        for (int i = 0; i < 5; i++) begin
            tv[i].par  = '0;
            tv[i].hand = 1'b0;
            tv[i].za   = 0;
            tv[i].ea   = '0;
            tv[i].zb   = 0;
            tv[i].eb   = '0;
        end
        tv[0].init = 0; tv[0].hand = 1'b1;
        tv[0].za = 5;  tv[0].ea = 25'd5;  tv[0].zb = 63; tv[0].eb = 25'd63;
        tv[1].init = 1; tv[1].hand = 1'b1; tv[1].par[0] = 1'b1;
        tv[1].za = 0;  tv[1].ea = 25'b01000_01000_01000_01000_01000;
        tv[1].zb = 1;  tv[1].eb = 25'b00001_00001_00001_00001_00001;
        tv[2].init = 1; tv[2].hand = 1'b1; tv[2].par[317] = 1'b1;
        tv[2].za = 63; tv[2].ea = 25'b00010_00010_00010_00010_00010;
        tv[2].zb = 0;  tv[2].eb = 25'b01000_01000_01000_01000_01000;
        rand_par(p);
        tv[3].init = 2; tv[3].par = p;
        tv[4].init = 2; tv[4].par = '1;

        for (int i = 0; i < 5; i++) begin
            init_mem(tv[i].init);
            base = done_cnt;
            drive_start(tv[i].par);
            wait_done(200);
            chk($sformatf("v%0d done_cycle", i), 64'(done_cyc - e0 + 1), 64'd129);
            start = 1'b0;
            repeat (4) tick();
            chk($sformatf("v%0d done_pulses", i), 64'(done_cnt - base), 64'd1);
            chk($sformatf("v%0d idle_busy", i), 64'(busy), 64'd0);
            chk($sformatf("v%0d sb_drained", i), 64'(exp_q.size()), 64'd0);
            mem_cmp($sformatf("v%0d mem", i), ref_mem);
            if (tv[i].hand) begin
                chk($sformatf("v%0d slice%0d", i, tv[i].za), 64'(mem[tv[i].za]), 64'(tv[i].ea));
                chk($sformatf("v%0d slice%0d", i, tv[i].zb), 64'(mem[tv[i].zb]), 64'(tv[i].eb));
            end
        end

        // Held start yields one run; a second run with the same parity restores memory.
        init_mem(2);
        rand_par(p);
        base = done_cnt;
        drive_start(p);
        repeat (399) tick();
        chk("hold done_pulses", 64'(done_cnt - base), 64'd1);
        chk("hold done_cycle", 64'(done_cyc - e0 + 1), 64'd129);
        chk("hold busy", 64'(busy), 64'd0);
        start = 1'b0;
        repeat (2) tick();
        drive_start(p);
        wait_done(200);
        start = 1'b0;
        repeat (3) tick();
        chk("rerun done_pulses", 64'(done_cnt - base), 64'd2);
        mem_cmp("rerun identity", orig);

        // Reset in the READ of slice 24: slices 0..23 written, the rest untouched.
        init_mem(2);
        rand_par(p);
        drive_start(p);
        repeat (48) tick();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        chk("rstmid busy",  64'(busy),      64'd0);
        chk("rstmid mem_r", 64'(mif.mem_r), 64'd0);
        chk("rstmid mem_w", 64'(mif.mem_w), 64'd0);
        chk("rstmid unwritten", 64'(exp_q.size()), 64'd40);
        exp_q.delete();
        for (int z = 0; z < 64; z++) snap[z] = (z < 24) ? ref_mem[z] : orig[z];
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rstmid idle_mem_w", 64'(mif.mem_w), 64'd0);
        mem_cmp("rstmid mem", snap);

`ifdef THETA_APPLY_ERR_EN
        // start dips low in cycle 11 and returns in cycle 12 while the run is in progress.
        init_mem(2);
        rand_par(p);
        drive_start(p);
        repeat (10) tick();
        start = 1'b0;
        tick();
        chk("err before edge", 64'(err), 64'd0);
        start = 1'b1;
        tick();
        chk("err cycle13", 64'(err), 64'd1);
        wait_done(200);
        chk("err done_cycle", 64'(done_cyc - e0 + 1), 64'd129);
        start = 1'b0;
        repeat (3) tick();
        chk("err sticky", 64'(err), 64'd1);
        mem_cmp("err mem", ref_mem);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
